// File: rtl/core_pkg.sv
// Shared RV32I core definitions: sequencer state encoding, NOP word, opcode[6:2] map.
package core_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH      = 3'd0,
      ST_WAIT_INSTR = 3'd1,
      ST_EXECUTE    = 3'd2,
      ST_WAIT_ALU   = 3'd3,
      ST_TRAP       = 3'd4
   } state_e;

   localparam logic [XLEN-1:0] NOP_INSTR          = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

   // opcode[6:2]; opcode[1:0] is always 2'b11 for 32-bit encodings
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

   function automatic logic is_rv32_encoding(input logic [XLEN-1:0] word);
      return word[1:0] == 2'b11;
   endfunction

endpackage

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: fetch, execute, shift wait, retire (PC + instret), sticky trap.
module core_ctrl_fsm
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
   input  logic            clk,
   input  logic            resetn,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_rstrb,
   input  logic            mem_rbusy,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] instr,
   input  logic            dec_wb_en,
   input  logic            dec_is_shift,
   output logic            alu_start,
   input  logic            alu_busy,
   input  logic [XLEN-1:0] pc_next,
   output logic [XLEN-1:0] pc,
   output logic            rf_we,
   output logic [XLEN-1:0] instret,
   output logic            halt
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instret_q, instret_d;
   logic            halt_q, halt_d;

   logic            retire_c;
   logic            rstrb_c;
   logic            alu_start_c;
   logic            rf_we_c;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_ADDR;
         instr_q   <= NOP_INSTR;
         instret_q <= '0;
         halt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
         halt_q    <= halt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      instret_d   = instret_q;
      halt_d      = halt_q;
      retire_c    = 1'b0;
      rstrb_c     = 1'b0;
      alu_start_c = 1'b0;
      rf_we_c     = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            rstrb_c = 1'b1;
            state_d = ST_WAIT_INSTR;
         end
         ST_WAIT_INSTR: begin
            if (!mem_rbusy) begin
               instr_d = mem_rdata;
               if (is_rv32_encoding(mem_rdata)) begin
                  state_d = ST_EXECUTE;
               end else begin
                  state_d = ST_TRAP;
                  halt_d  = 1'b1;
               end
            end
         end
         ST_EXECUTE: begin
            if (dec_is_shift) begin
               alu_start_c = 1'b1;
               state_d     = ST_WAIT_ALU;
            end else begin
               retire_c = 1'b1;
            end
         end
         ST_WAIT_ALU: begin
            if (!alu_busy) begin
               retire_c = 1'b1;
            end
         end
         ST_TRAP: begin
            halt_d = 1'b1;
         end
         default: begin
            state_d = ST_TRAP;
            halt_d  = 1'b1;
         end
      endcase

      // A misaligned next PC is never committed; the retire turns into a trap
      if (retire_c) begin
         if (is_word_aligned(pc_next)) begin
            rf_we_c   = dec_wb_en;
            pc_d      = pc_next;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
         end else begin
            state_d = ST_TRAP;
            halt_d  = 1'b1;
         end
      end
   end

   // Strobes are forced low while reset is asserted, since state already reads FETCH
   assign mem_rstrb = rstrb_c & resetn;
   assign alu_start = alu_start_c & resetn;
   assign rf_we     = rf_we_c & resetn;

   assign mem_addr  = pc_q;
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign instret   = instret_q;
   assign halt      = halt_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: per-instruction scoreboard of committed pc/instret/instr.
module tb_core_ctrl_fsm;

   localparam logic [31:0] RST_ADDR = 32'h0000_0000;
   localparam logic [31:0] NOP_W    = 32'h0000_0013;
   localparam logic [31:0] ADD_W    = 32'h003100B3;
   localparam logic [31:0] SLL_W    = 32'h002090B3;
   localparam logic [31:0] SW_W     = 32'h0020A023;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic        mem_rbusy;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic        dec_wb_en;
   logic        dec_is_shift;
   logic        alu_start;
   logic        alu_busy;
   logic [31:0] pc_next;
   logic [31:0] pc;
   logic        rf_we;
   logic [31:0] instret;
   logic        halt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instret;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          strobes = 0;
   int          exp_strobes = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_instret;
   logic [31:0] exp_instr;

   core_ctrl_fsm #(.RESET_ADDR(RST_ADDR)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .mem_addr     (mem_addr),
      .mem_rstrb    (mem_rstrb),
      .mem_rbusy    (mem_rbusy),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .dec_wb_en    (dec_wb_en),
      .dec_is_shift (dec_is_shift),
      .alu_start    (alu_start),
      .alu_busy     (alu_busy),
      .pc_next      (pc_next),
      .pc           (pc),
      .rf_we        (rf_we),
      .instret      (instret),
      .halt         (halt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rstrb === 1'b1) strobes <= strobes + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_rbusy    = 1'b0;
      mem_rdata    = 32'h0;
      dec_wb_en    = 1'b0;
      dec_is_shift = 1'b0;
      alu_busy     = 1'b0;
      pc_next      = 32'h0;
   endtask

   // Asserts reset mid-cycle, checks outputs before any clock edge, releases on a falling edge
   task automatic do_reset(input string tag);
      resetn = 1'b0;
      #1;
      chk({tag, "_pc"}, pc, RST_ADDR);
      chk({tag, "_instr"}, instr, NOP_W);
      chk({tag, "_instret"}, instret, 32'h0);
      chk({tag, "_halt"}, {31'b0, halt}, 32'h0);
      chk({tag, "_rstrb"}, {31'b0, mem_rstrb}, 32'h0);
      chk({tag, "_alu_start"}, {31'b0, alu_start}, 32'h0);
      chk({tag, "_rf_we"}, {31'b0, rf_we}, 32'h0);
      @(negedge clk);
      clear_inputs();
      resetn = 1'b1;
      #1;
      exp_pc      = RST_ADDR;
      exp_instret = 32'h0;
      exp_instr   = NOP_W;
      sb_q.delete();
   endtask

   // Runs one instruction starting in FETCH; returns either back in FETCH or in TRAP
   task automatic run_instr(input logic [31:0] word, input int nbusy, input logic shift,
                            input int nalu, input logic wbe, input logic [31:0] pcn);
      logic aligned;
      exp_t e;
      aligned = (pcn[1:0] == 2'b00);
      chk("fetch_rstrb", {31'b0, mem_rstrb}, 32'h1);
      chk("fetch_addr", mem_addr, exp_pc);
      exp_strobes++;
      mem_rbusy = 1'b0;
      tick();
      for (int i = 0; i < nbusy; i++) begin
         mem_rbusy = 1'b1;
         mem_rdata = 32'hDEAD_BEEF;
         #1;
         chk("wait_rstrb", {31'b0, mem_rstrb}, 32'h0);
         tick();
         chk("busy_instr_hold", instr, exp_instr);
      end
      mem_rbusy = 1'b0;
      mem_rdata = word;
      tick();
      exp_instr = word;
      chk("instr_latch", instr, exp_instr);
      if (word[1:0] != 2'b11) begin
         chk("fetch_trap_halt", {31'b0, halt}, 32'h1);
         return;
      end
      mem_rbusy    = 1'b1;
      mem_rdata    = 32'h0;
      dec_is_shift = shift;
      dec_wb_en    = wbe;
      pc_next      = pcn;
      if (aligned) sb_q.push_back('{pcn, exp_instret + 32'd1, word});
      #1;
      chk("exec_alu_start", {31'b0, alu_start}, {31'b0, shift});
      if (shift) begin
         chk("exec_no_we", {31'b0, rf_we}, 32'h0);
         tick();
         for (int i = 0; i < nalu; i++) begin
            alu_busy = 1'b1;
            #1;
            chk("alu_wait_we", {31'b0, rf_we}, 32'h0);
            chk("alu_wait_start", {31'b0, alu_start}, 32'h0);
            tick();
         end
         alu_busy = 1'b0;
         #1;
      end
      chk("retire_we", {31'b0, rf_we}, {31'b0, aligned & wbe});
      tick();
      clear_inputs();
      #1;
      if (aligned) begin
         e = sb_q.pop_front();
         chk("retire_pc", pc, e.pc);
         chk("retire_instret", instret, e.instret);
         chk("retire_instr", instr, e.instr);
         exp_pc      = e.pc;
         exp_instret = e.instret;
         chk("back_to_fetch", {31'b0, mem_rstrb}, 32'h1);
         chk("strobe_count", 32'(strobes), 32'(exp_strobes));
      end else begin
         chk("misalign_halt", {31'b0, halt}, 32'h1);
         chk("misalign_pc", pc, exp_pc);
         chk("misalign_instret", instret, exp_instret);
         chk("misalign_rstrb", {31'b0, mem_rstrb}, 32'h0);
      end
   endtask

   task automatic trap_idle(input string tag);
      int s0;
      s0 = strobes;
      for (int i = 0; i < 20; i++) tick();
      chk({tag, "_no_fetch"}, 32'(strobes), 32'(s0));
      chk({tag, "_halt_sticky"}, {31'b0, halt}, 32'h1);
      chk({tag, "_pc_hold"}, pc, exp_pc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      clear_inputs();
      #12;
      do_reset("reset");

      run_instr(ADD_W, 0, 1'b0, 0, 1'b1, 32'h4);
      run_instr(NOP_W, 4, 1'b0, 0, 1'b1, 32'h8);
      run_instr(SLL_W, 0, 1'b1, 5, 1'b1, 32'hC);
      run_instr(SW_W,  1, 1'b0, 0, 1'b0, 32'h10);
      run_instr(SLL_W, 0, 1'b1, 0, 1'b1, 32'h14);

      run_instr(ADD_W, 0, 1'b0, 0, 1'b1, 32'h0000_0006);
      trap_idle("misalign");
      do_reset("reset2");
      chk("restart_rstrb", {31'b0, mem_rstrb}, 32'h1);

      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      exp_instret = 32'hFFFF_FFFF;
      chk("preload_instret", instret, exp_instret);
      run_instr(ADD_W, 0, 1'b0, 0, 1'b1, 32'h4);
      chk("wrap_instret", instret, 32'h0);

      run_instr(32'h0000_0000, 0, 1'b0, 0, 1'b0, 32'h8);
      chk("fetch_trap_instr", instr, 32'h0);
      trap_idle("badop");
      do_reset("reset3");

      // abandon a shift in WAIT_ALU with alu_busy still high
      exp_strobes++;
      tick();
      mem_rdata = SLL_W;
      tick();
      dec_is_shift = 1'b1;
      dec_wb_en    = 1'b1;
      pc_next      = 32'h4;
      #1;
      chk("abort_exec_start", {31'b0, alu_start}, 32'h1);
      tick();
      alu_busy = 1'b1;
      tick();
      #1;
      do_reset("reset_mid_alu");
      alu_busy = 1'b1;
      #1;
      chk("post_abort_rstrb", {31'b0, mem_rstrb}, 32'h1);
      alu_busy = 1'b0;
      run_instr(ADD_W, 0, 1'b0, 0, 1'b1, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I core.
- Fetches an instruction from memory and latches it onto the bus that feeds mini_decoder.
- Runs the execute step, waits on the ALU for shift ops, commits register write-back and the PC update, and counts retired instructions.
- Sits between instruction memory, mini_decoder, the ALU and the register file.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset (must be word-aligned)

Ports:
clk  in  1  system clock, all state updates on rising edge
resetn  in  1  asynchronous, active-low reset
mem_addr  out  32  instruction fetch address, equals pc
mem_rstrb  out  1  fetch request strobe, single-cycle pulse
mem_rbusy  in  1  memory busy; mem_rdata valid in a WAIT_INSTR cycle with mem_rbusy=0
mem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction, drives mini_decoder.instr
dec_wb_en  in  1  mini_decoder writeBackEn for the current instr
dec_is_shift  in  1  current instr is a shift (func3 001/101, ALU opcode)
alu_start  out  1  one-cycle pulse launching a multi-cycle shift
alu_busy  in  1  ALU shift in progress
pc_next  in  32  next PC computed by the datapath for the current instr
pc  out  32  current program counter
rf_we  out  1  register-file write enable, one cycle per retired instr
instret  out  32  retired-instruction counter
halt  out  1  sticky trap indicator

Behaviour:
- Reset (async, resetn=0):
  - state=FETCH, pc=RESET_ADDR, instr=32'h0000_0013 (NOP), instret=0, halt=0.
  - mem_rstrb=alu_start=rf_we=0 immediately.
  - Reset mid-fetch or mid-shift abandons the operation; a late mem_rdata or alu_busy is ignored.
- States: FETCH, WAIT_INSTR, EXECUTE, WAIT_ALU, TRAP. State register is the only source of sequencing.
- FETCH:
  - mem_rstrb=1 for exactly this cycle, mem_addr=pc.
  - Next state is WAIT_INSTR.
- WAIT_INSTR:
  - If mem_rbusy=1, stay in WAIT_INSTR.
  - If mem_rbusy=0, latch instr<=mem_rdata. Zero-wait memory, where the first WAIT_INSTR cycle already has mem_rbusy=0, is legal.
  - If mem_rdata[1:0]!=2'b11, go to TRAP (instr still latched). Otherwise go to EXECUTE.
- EXECUTE (one cycle):
  - If dec_is_shift=1: alu_start=1, next state WAIT_ALU. No commit this cycle.
  - Otherwise retire: rf_we=dec_wb_en, pc<=pc_next, instret<=instret+1, next state FETCH.
- WAIT_ALU:
  - The ALU must raise alu_busy no later than the cycle after alu_start; alu_busy=0 in the first WAIT_ALU cycle means zero-extra-cycle completion.
  - If alu_busy=1, stay.
  - If alu_busy=0, retire as in EXECUTE and go to FETCH.
- Retire check: if pc_next[1:0]!=2'b00, go to TRAP instead of FETCH.
  - pc, instret and rf_we are not updated on that cycle.
  - Misaligned PC is never committed.
- TRAP:
  - halt=1 and all strobes 0.
  - Stays in TRAP until resetn is asserted; no further fetches.
- Output timing:
  - mem_rstrb, alu_start and rf_we are combinational decodes of registered state plus dec_*/alu_busy/pc_next. Downstream samples them at the next rising edge.
  - pc, instr, instret and halt are registered.
- Arithmetic: instret is a 32-bit unsigned counter that wraps 32'hFFFF_FFFF -> 0 with no flag.
- Latency:
  - Non-shift instr, zero-wait memory: 3 cycles (FETCH, WAIT_INSTR, EXECUTE).
  - Each mem_rbusy cycle adds 1.
  - A shift adds 1 + (number of alu_busy=1 cycles).
- Simultaneous events: mem_rbusy and alu_busy are ignored outside their wait states. dec_* inputs are used only in EXECUTE/WAIT_ALU.

Decomposition:
- Shared package core_pkg holds:
  - state encoding localparams (3-bit);
  - NOP constant 32'h0000_0013;
  - RV32I opcode[6:2] constants (OP=5'b01100, OP_IMM=5'b00100, ...), shared with mini_decoder;
  - default RESET_ADDR.
- No sub-module: the FSM, PC register and instret counter are implemented in one module.

Test Plan:
- Zero-wait memory returning ADD x1,x2,x3 (32'h003100B3), pc_next=pc+4 -> 3 cycles; rf_we=1 in EXECUTE; pc 0->4; instret 0->1; mem_rstrb pulses once per instruction.
- mem_rbusy held high 4 cycles after strobe, then 32'h00000013 -> stays in WAIT_INSTR 4 cycles; instr updated only on the rbusy=0 cycle; total 7 cycles to retire.
- SLL, dec_is_shift=1, alu_busy high 5 cycles -> alu_start single pulse in EXECUTE; rf_we=1 only on the first alu_busy=0 cycle; pc advances once.
- mem_rdata=32'h00000000 (bits[1:0]=00) -> TRAP; halt=1 sticky; no further mem_rstrb for 20 cycles; resetn pulse -> pc=RESET_ADDR, halt=0, fetch restarts.
- pc_next=32'h0000_0006 at retire -> TRAP; pc unchanged; instret unchanged; rf_we=0.
- Preload instret near wrap by retiring until 32'hFFFF_FFFF (force/backdoor), retire once more -> instret=0. Assert resetn=0 mid-WAIT_ALU -> all outputs at reset values in the same cycle, without waiting for a clock edge.
